// File: rtl/mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier that borrows an external ALU for the adds.
`default_nettype none

package mul_seq_pkg;
  localparam logic [4:0] kMOV = 5'h00;
  localparam logic [4:0] kADD = 5'h01;
endpackage

module mul_seq
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic [4:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_co,
  output logic        busy,
  output logic        done,
  output logic [15:0] prod
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mc_q, mc_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        c_q, c_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_d    = mcand;
          hi_d    = 8'd0;
          lo_d    = mplier;
          c_d     = 1'b0;
          cnt_d   = 3'd0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (lo_q[0] && !c_q) begin
          {c_d, hi_d} = {alu_co, alu_rslt};
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {c_d, hi_d, lo_d} = {1'b0, c_q, hi_q, lo_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          prod_d  = {c_q, hi_q, lo_q[7:1]};
          state_d = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    alu_op_d = (state_d == S_ADD) ? kADD : kMOV;
    alu_a_d  = (state_d == S_ADD) ? hi_d : 8'd0;
    alu_b_d  = (state_d == S_ADD) ? mc_d : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mc_q     <= 8'd0;
      hi_q     <= 8'd0;
      lo_q     <= 8'd0;
      c_q      <= 1'b0;
      cnt_q    <= 3'd0;
      prod_q   <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_op_q <= kMOV;
      alu_a_q  <= 8'd0;
      alu_b_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      mc_q     <= mc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign prod   = prod_q;
  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: models the shared ALU and compares against plain integer multiplication.
`default_nettype none

module tb_mul_seq;
  import mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand, mplier;
  logic [4:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_co;
  logic        busy, done;
  logic [15:0] prod;

  int n_checks = 0;
  int n_errors = 0;
  int add_cnt  = 0;
  int bad_alu  = 0;
  int exp_mc   = 0;
  int exp_mp   = 0;

  mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_rslt (alu_rslt),
    .alu_co   (alu_co),
    .busy     (busy),
    .done     (done),
    .prod     (prod)
  );

  always #5 clk = ~clk;

  always_comb begin
    {alu_co, alu_rslt} = 9'd0;
    if (alu_op == kADD) {alu_co, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_op == kMOV) alu_rslt = alu_a;
  end

  // During the k-th add the running high byte is the partial product of the
  // low k multiplier bits, shifted right by k.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_op == kADD) begin
        if (int'(alu_b) != exp_mc ||
            int'(alu_a) != ((exp_mc * (exp_mp % (1 << add_cnt))) >> add_cnt))
          bad_alu++;
        add_cnt++;
      end else if (alu_op != kMOV || alu_a != 8'd0 || alu_b != 8'd0) begin
        bad_alu++;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  task automatic do_mul(input int a, input int b);
    int n;
    @(negedge clk);
    exp_mc = a; exp_mp = b; add_cnt = 0;
    mcand = a[7:0]; mplier = b[7:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mcand = 8'($urandom); mplier = 8'($urandom);
    wait_done(n);
    check("latency", n, 17);
    check("prod", int'(prod), a * b);
    check("add_count", add_cnt, 8);
    check("busy_in_done", int'(busy), 1);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("busy_after", int'(busy), 0);
  endtask

  initial begin
    int n;
    int saw_done;
    rst_n = 1'b0; start = 1'b0; mcand = 8'd0; mplier = 8'd0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_prod", int'(prod), 0);
    check("rst_alu_op", int'(alu_op), int'(kMOV));
    check("rst_alu_ab", int'({alu_a, alu_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_mul(13, 11);
    do_mul(255, 255);
    do_mul(0, 200);
    do_mul(1, 128);
    do_mul(200, 0);

    // start held high with new operands throughout a 7*9 multiply
    @(negedge clk);
    exp_mc = 7; exp_mp = 9; add_cnt = 0;
    mcand = 8'd7; mplier = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    mcand = 8'd3; mplier = 8'd3;
    wait_done(n);
    check("lock_latency", n, 17);
    check("lock_prod1", int'(prod), 63);
    check("lock_adds1", add_cnt, 8);
    exp_mc = 3; exp_mp = 3; add_cnt = 0;
    @(negedge clk);
    check("lock_idle", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("prod_hold", int'(prod), 63);
    wait_done(n);
    check("lock_latency2", n, 12);
    check("lock_prod2", int'(prod), 9);
    check("lock_adds2", add_cnt, 8);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    exp_mc = 100; exp_mp = 100; add_cnt = 0;
    mcand = 8'd100; mplier = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_prod", int'(prod), 0);
    check("midrst_alu_op", int'(alu_op), int'(kMOV));
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_prod", int'(prod), 0);
    check("abort_busy", int'(busy), 0);
    do_mul(100, 100);

    for (int i = 0; i < 1500; i++) begin
      do_mul(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
    end

    check("alu_protocol", bad_alu, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
